pulse_sequencer: RTL and testbench

PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

---
 rtl/pulse_pkg.sv | 15 +
 rtl/pulse_channel.sv | 150 +++++++++++++++
 rtl/pulse_sequencer.sv | 60 ++++++
 tb/tb_pulse_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared types and default sizes for the pulse sequencer and its channels.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        HIGH  = 2'd2,
        GAP   = 2'd3
    } ch_state_e;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_CNT_W   = 32;
    localparam int DEF_BURST_W = 8;

endpackage

// File: rtl/pulse_channel.sv
// One pulse channel: delay, pulse high time and (with PULSE_SEQ_BURST_EN) gap/burst repeats.
// Outputs are decoded from registered state, so they change only on clock edges.
module pulse_channel
    import pulse_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trig_edge_i,
    input  logic               enable_i,
    input  logic               abort_i,
    input  logic [CNT_W-1:0]   delay_i,
    input  logic [CNT_W-1:0]   width_i,
    input  logic [CNT_W-1:0]   gap_i,
    input  logic [BURST_W-1:0] burst_i,
    output logic               pulse_o,
    output logic               running_o,
    output logic               done_o,
    output logic               missed_o
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] width_last;
    logic             done_q, done_d;
    logic             missed_q, missed_d;
    logic             busy;

`ifdef PULSE_SEQ_BURST_EN
    logic [CNT_W-1:0]   gap_q, gap_d, gap_last;
    logic [BURST_W-1:0] rem_q, rem_d;

    assign gap_last = (gap_q == '0) ? '0 : gap_q - CNT_W'(1);
`else
    logic unused_cfg;

    assign unused_cfg = ^{gap_i, burst_i};
`endif

    assign busy       = (state_q != IDLE);
    // Counters compare against length-1, so an all-ones length never needs to wrap.
    assign width_last = (width_q == '0) ? '0 : width_q - CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        delay_d  = delay_q;
        width_d  = width_q;
        done_d   = 1'b0;
        missed_d = trig_edge_i & enable_i & busy & ~abort_i;
`ifdef PULSE_SEQ_BURST_EN
        gap_d    = gap_q;
        rem_d    = rem_q;
`endif
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trig_edge_i && enable_i) begin
                        delay_d = delay_i;
                        width_d = width_i;
                        cnt_d   = '0;
`ifdef PULSE_SEQ_BURST_EN
                        gap_d   = gap_i;
                        rem_d   = (burst_i == '0) ? '0 : burst_i - BURST_W'(1);
`endif
                        // A zero delay has no DELAY cycles: the pulse starts on the next edge.
                        state_d = (delay_i == '0) ? HIGH : DELAY;
                    end
                end
                DELAY: begin
                    if (cnt_q == delay_q - CNT_W'(1)) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (cnt_q == width_last) begin
                        cnt_d = '0;
`ifdef PULSE_SEQ_BURST_EN
                        if (rem_q == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = GAP;
                            rem_d   = rem_q - BURST_W'(1);
                        end
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef PULSE_SEQ_BURST_EN
                GAP: begin
                    if (cnt_q == gap_last) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            delay_q  <= '0;
            width_q  <= '0;
            done_q   <= 1'b0;
            missed_q <= 1'b0;
`ifdef PULSE_SEQ_BURST_EN
            gap_q    <= '0;
            rem_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            delay_q  <= delay_d;
            width_q  <= width_d;
            done_q   <= done_d;
            missed_q <= missed_d;
`ifdef PULSE_SEQ_BURST_EN
            gap_q    <= gap_d;
            rem_q    <= rem_d;
`endif
        end
    end

    assign pulse_o   = (state_q == HIGH);
    assign running_o = busy;
    assign done_o    = done_q;
    assign missed_o  = missed_q;

endmodule

// File: rtl/pulse_sequencer.sv
// Multi-channel pulse sequencer: shared trigger edge detector feeding NUM_CH pulse channels.
// Burst/gap support is compiled in only when PULSE_SEQ_BURST_EN is defined.
module pulse_sequencer
    import pulse_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      trigger_in,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [NUM_CH-1:0]         abort,
    input  logic [NUM_CH*CNT_W-1:0]   delay,
    input  logic [NUM_CH*CNT_W-1:0]   width,
    input  logic [NUM_CH*CNT_W-1:0]   gap,
    input  logic [NUM_CH*BURST_W-1:0] burst,
    output logic [NUM_CH-1:0]         pulse_out,
    output logic [NUM_CH-1:0]         running,
    output logic [NUM_CH-1:0]         done,
    output logic [NUM_CH-1:0]         missed
);

    logic trig_q;
    logic trig_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trigger_in;
        end
    end

    // A held-high trigger produces a single edge.
    assign trig_edge = trigger_in & ~trig_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pulse_channel #(
            .CNT_W   (CNT_W),
            .BURST_W (BURST_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .trig_edge_i (trig_edge),
            .enable_i    (ch_enable[i]),
            .abort_i     (abort[i]),
            .delay_i     (delay[i*CNT_W +: CNT_W]),
            .width_i     (width[i*CNT_W +: CNT_W]),
            .gap_i       (gap[i*CNT_W +: CNT_W]),
            .burst_i     (burst[i*BURST_W +: BURST_W]),
            .pulse_o     (pulse_out[i]),
            .running_o   (running[i]),
            .done_o      (done[i]),
            .missed_o    (missed[i])
        );
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: timeline model of each channel's sequence plus directed literal checks.
module tb_pulse_sequencer;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 6;
    localparam int BURST_W = 3;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int BMAX    = (1 << BURST_W) - 1;

    logic                      clk        = 1'b0;
    logic                      rst_n      = 1'b1;
    logic                      trigger_in = 1'b0;
    logic [NUM_CH-1:0]         ch_enable  = '0;
    logic [NUM_CH-1:0]         abort      = '0;
    logic [NUM_CH*CNT_W-1:0]   delay      = '0;
    logic [NUM_CH*CNT_W-1:0]   width      = '0;
    logic [NUM_CH*CNT_W-1:0]   gap        = '0;
    logic [NUM_CH*BURST_W-1:0] burst      = '0;
    logic [NUM_CH-1:0]         pulse_out, running, done, missed;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pulse_sequencer #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trigger_in (trigger_in),
        .ch_enable  (ch_enable),
        .abort      (abort),
        .delay      (delay),
        .width      (width),
        .gap        (gap),
        .burst      (burst),
        .pulse_out  (pulse_out),
        .running    (running),
        .done       (done),
        .missed     (missed)
    );

    // Model: each started sequence is a timeline relative to the edge that launched it.
    longint cyc    = 0;
    bit     m_prev = 1'b0;
    bit     m_act  [NUM_CH];
    bit     m_miss [NUM_CH];
    longint m_t0 [NUM_CH];
    longint m_d  [NUM_CH];
    longint m_w  [NUM_CH];
    longint m_g  [NUM_CH];
    longint m_n  [NUM_CH];

    function automatic longint seq_len(int c);
        return m_d[c] + m_n[c] * m_w[c] + (m_n[c] - 1) * m_g[c];
    endfunction

    function automatic bit pulse_at(int c, longint rel);
        longint x, per;
        if (rel < m_d[c]) return 1'b0;
        x   = rel - m_d[c];
        per = m_w[c] + m_g[c];
        return ((x / per) < m_n[c]) && ((x % per) < m_w[c]);
    endfunction

    task automatic model_step();
        bit edge_s;
        bit busy;
        edge_s = trigger_in && !m_prev;
        m_prev = trigger_in;
        cyc++;
        for (int c = 0; c < NUM_CH; c++) begin
            busy      = m_act[c] && ((cyc - 1 - m_t0[c]) < seq_len(c));
            m_miss[c] = 1'b0;
            if (abort[c]) begin
                m_act[c] = 1'b0;
            end else if (edge_s && ch_enable[c]) begin
                if (busy) begin
                    m_miss[c] = 1'b1;
                end else begin
                    m_act[c] = 1'b1;
                    m_t0[c]  = cyc;
                    m_d[c]   = longint'(delay[c*CNT_W +: CNT_W]);
                    m_w[c]   = (width[c*CNT_W +: CNT_W] == 0) ? 1 : longint'(width[c*CNT_W +: CNT_W]);
                    m_g[c]   = (gap[c*CNT_W +: CNT_W] == 0) ? 1 : longint'(gap[c*CNT_W +: CNT_W]);
`ifdef PULSE_SEQ_BURST_EN
                    m_n[c]   = (burst[c*BURST_W +: BURST_W] == 0) ? 1 : longint'(burst[c*BURST_W +: BURST_W]);
`else
                    m_n[c]   = 1;
`endif
                end
            end
        end
    endtask

    task automatic model_reset();
        m_prev = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_act[c]  = 1'b0;
            m_miss[c] = 1'b0;
        end
    endtask

    task automatic check(string name, logic [NUM_CH-1:0] act, logic [NUM_CH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic pin(string name, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0] ep, er, ed, em;
        longint rel, len;
        for (int c = 0; c < NUM_CH; c++) begin
            rel   = cyc - m_t0[c];
            len   = seq_len(c);
            er[c] = m_act[c] && (rel < len);
            ep[c] = er[c] && pulse_at(c, rel);
            ed[c] = m_act[c] && (rel == len);
            em[c] = m_miss[c];
        end
        check("pulse_out", pulse_out, ep);
        check("running", running, er);
        check("done", done, ed);
        check("missed", missed, em);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(int n);
        trigger_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic set_ch(int c, int d, int w, int g, int b);
        delay[c*CNT_W +: CNT_W]   = CNT_W'(d);
        width[c*CNT_W +: CNT_W]   = CNT_W'(w);
        gap[c*CNT_W +: CNT_W]     = CNT_W'(g);
        burst[c*BURST_W +: BURST_W] = BURST_W'(b);
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        check("reset_pulse_out", pulse_out, '0);
        check("reset_running", running, '0);
        check("reset_done", done, '0);
        check("reset_missed", missed, '0);
        model_reset();
        trigger_in = 1'b0;
        abort      = '0;
        repeat (2) @(posedge clk);
        #1 check("reset_held_running", running, '0);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int hi, dn, first, rises;
        logic prevp;

        apply_reset();

        // Single pulse: delay 3, width 2 -> high at E0+4..E0+5, done at E0+6.
        ch_enable = 4'b0001;
        set_ch(0, 3, 2, 0, 1);
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        for (int r = 0; r < 8; r++) begin
            pin("single_pulse", pulse_out[0], (r == 3 || r == 4));
            pin("single_done", done[0], (r == 5));
            tick();
        end

        // Burst: delay 0, width 1, gap 2, burst 3.
        set_ch(0, 0, 1, 2, 3);
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        for (int r = 0; r < 10; r++) begin
`ifdef PULSE_SEQ_BURST_EN
            pin("burst_pulse", pulse_out[0], (r == 0 || r == 3 || r == 6));
            pin("burst_done", done[0], (r == 7));
`else
            pin("burst_off_pulse", pulse_out[0], (r == 0));
            pin("burst_off_done", done[0], (r == 1));
`endif
            tick();
        end

        // Busy trigger during HIGH: missed once, sequence unchanged.
        set_ch(0, 1, 6, 0, 1);
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        tick();
        tick();
        trigger_in = 1'b1;
        tick();
        pin("busy_missed", missed[0], 1);
        pin("busy_pulse", pulse_out[0], 1);
        trigger_in = 1'b0;
        tick();
        pin("busy_missed_once", missed[0], 0);
        repeat (3) tick();
        pin("busy_done", done[0], 1);
        idle(3);

        // Abort during DELAY: running low from E0+3, no pulse, no done.
        set_ch(0, 5, 2, 0, 1);
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        tick();
        abort = 4'b0001;
        tick();
        abort = '0;
        pin("abort_running", running[0], 0);
        hi = 0;
        dn = 0;
        for (int r = 0; r < 10; r++) begin
            tick();
            hi += int'(pulse_out[0]);
            dn += int'(done[0]);
        end
        pin("abort_no_pulse", hi, 0);
        pin("abort_no_done", dn, 0);

        // Reset in the middle of a pulse, then a normal trigger.
        set_ch(0, 0, 10, 0, 1);
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        tick();
        tick();
        pin("pre_reset_pulse", pulse_out[0], 1);
        apply_reset();
        set_ch(0, 2, 1, 0, 1);
        tick();
        pin("post_reset_no_done", done[0], 0);
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        for (int r = 0; r < 5; r++) begin
            pin("post_reset_pulse", pulse_out[0], (r == 2));
            pin("post_reset_done", done[0], (r == 3));
            tick();
        end

        // Trigger held high for 20 cycles: exactly one sequence.
        set_ch(0, 0, 2, 0, 1);
        trigger_in = 1'b1;
        rises = 0;
        dn    = 0;
        prevp = 1'b0;
        for (int r = 0; r < 20; r++) begin
            tick();
            if (pulse_out[0] && !prevp) rises++;
            prevp = pulse_out[0];
            dn += int'(done[0]);
        end
        pin("held_one_pulse", rises, 1);
        pin("held_one_done", dn, 1);
        idle(3);

        // Width 0 behaves as width 1.
        set_ch(0, 1, 0, 0, 1);
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        hi = 0;
        for (int r = 0; r < 6; r++) begin
            hi += int'(pulse_out[0]);
            tick();
        end
        pin("width0_len", hi, 1);

        // Disabled channel ignores the trigger.
        ch_enable = 4'b1110;
        set_ch(0, 0, 3, 0, 1);
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        dn = 0;
        for (int r = 0; r < 6; r++) begin
            dn += int'(running[0]) + int'(pulse_out[0]) + int'(done[0]) + int'(missed[0]);
            tick();
        end
        pin("disabled_quiet", dn, 0);
        idle(10);

        // All-ones counters and burst count terminate normally.
        ch_enable = 4'b0010;
        set_ch(1, CMAX, CMAX, CMAX, BMAX);
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        hi    = 0;
        dn    = 0;
        first = -1;
        for (int r = 0; r < 1000 && dn == 0; r++) begin
            if (pulse_out[1]) begin
                hi++;
                if (first < 0) first = r;
            end
            dn += int'(done[1]);
            tick();
        end
        pin("allones_first", first, CMAX);
`ifdef PULSE_SEQ_BURST_EN
        pin("allones_high", hi, BMAX * CMAX);
`else
        pin("allones_high", hi, CMAX);
`endif
        pin("allones_done", dn, 1);
        idle(3);

        // Randomised traffic against the timeline model.
        ch_enable = '1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) trigger_in = ~trigger_in;
            if ($urandom_range(15) == 0) ch_enable = NUM_CH'($urandom);
            for (int c = 0; c < NUM_CH; c++) begin
                abort[c] = ($urandom_range(39) == 0);
                set_ch(c, int'($urandom_range(7)), int'($urandom_range(5)),
                       int'($urandom_range(4)), int'($urandom_range(4)));
            end
            tick();
        end
        abort = '0;
        idle(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
